// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth sequential multiplier.
package booth_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // Booth codes on {Q[0], q_{-1}}
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of {A, Q, q_{-1}}.
module booth_step
  import booth_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N:0]   a_i,
  input  logic [N-1:0] q_i,
  input  logic         qm1_i,
  input  logic [N-1:0] m_i,
  output logic [N:0]   a_o,
  output logic [N-1:0] q_o,
  output logic         qm1_o
);

  logic [N:0] m_ext_s;
  logic [N:0] sum_s;

  assign m_ext_s = {m_i[N-1], m_i};

  // Select add, subtract or pass-through from the scanned bit pair.
  always_comb begin
    sum_s = a_i;
    case ({q_i[0], qm1_i})
      BOOTH_ADD: sum_s = a_i + m_ext_s;
      BOOTH_SUB: sum_s = a_i - m_ext_s;
      default:   sum_s = a_i;
    endcase
  end

  assign a_o   = {sum_s[N], sum_s[N:1]};
  assign q_o   = {sum_s[0], q_i[N-1:1]};
  assign qm1_o = q_i[0];

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed multiplier: one Booth step per CALC cycle, N steps per
// product, result registered on entry to DONE and held until the next one.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int WIDTH = 2*N
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [N-1:0]     multiplicand,
  input  logic signed [N-1:0]     multiplier,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] product
);

  localparam int CW = $clog2(N + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N:0]     a_q, a_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   m_q, m_d;
  logic           qm1_q, qm1_d;
  logic [WIDTH-1:0] product_q, product_d;

  logic [N:0]     a_s;
  logic [N-1:0]   q_s;
  logic           qm1_s;
  logic signed [2*N:0] full_s;

  booth_step #(.N(N)) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .a_o   (a_s),
    .q_o   (q_s),
    .qm1_o (qm1_s)
  );

  // A carries the guard bit, so {A, Q} is the exact product before resizing.
  assign full_s = {a_s, q_s};

  // Next-state, datapath capture and product load.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    qm1_d     = qm1_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(N);
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        a_d   = a_s;
        q_d   = q_s;
        qm1_d = qm1_s;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          product_d = WIDTH'(full_s);
        end else begin
          state_d = CALC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      qm1_q     <= qm1_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and exhaustive checks of booth_seq_mult at N=4.
module tb_booth_seq_mult;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] multiplicand;
  logic [N-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [W-1:0] product;

  int checks;
  int failures;

  booth_seq_mult #(.N(N), .WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one multiply; report cycles from the start edge to done, and busy count.
  task automatic do_mult(input logic [N-1:0] mc, input logic [N-1:0] mp,
                         output int lat, output int busy_cnt, output bit seen);
    multiplicand = mc;
    multiplier   = mp;
    start        = 1'b1;
    tick();
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    seen = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
      failures++;
      $display("FAIL reset busy=%b done=%b product=%h expected 0 0 00", busy, done, product);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, bc; bit seen;
    do_mult(4'd3, 4'hE, lat, bc, seen);
    checks++;
    if (!seen || product !== 8'hFA) begin
      failures++;
      $display("FAIL basic_3x-2 seen=%b product=%h expected 1 fa", seen, product);
    end
    checks++;
    if (lat !== 4 || bc !== 4) begin
      failures++;
      $display("FAIL basic_timing lat=%0d busy=%0d expected 4 4", lat, bc);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 8'hFA) begin
      failures++;
      $display("FAIL basic_hold done=%b busy=%b product=%h expected 0 0 fa", done, busy, product);
    end
  endtask

  task automatic test_corners();
    int lat, bc; bit seen;
    do_mult(4'h8, 4'h8, lat, bc, seen);
    checks++;
    if (!seen || product !== 8'h40) begin
      failures++;
      $display("FAIL corner_-8x-8 seen=%b product=%h expected 1 40", seen, product);
    end
    do_mult(4'h7, 4'h8, lat, bc, seen);
    checks++;
    if (!seen || product !== 8'hC8) begin
      failures++;
      $display("FAIL corner_7x-8 seen=%b product=%h expected 1 c8", seen, product);
    end
  endtask

  task automatic test_no_restart();
    int lat;
    multiplicand = 4'd5; multiplier = 4'hD; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || product !== 8'hC8) begin
      failures++;
      $display("FAIL calc_hold busy=%b product=%h expected 1 c8", busy, product);
    end
    tick();
    multiplicand = 4'd7; multiplier = 4'd7; start = 1'b1;
    tick();
    start = 1'b0; multiplicand = 4'h1; multiplier = 4'h2;
    lat = 2;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (done !== 1'b1 || lat !== 4 || product !== 8'hF1) begin
      failures++;
      $display("FAIL no_restart done=%b lat=%0d product=%h expected 1 4 f1", done, lat, product);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL no_restart_idle busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc; bit seen, saw_done;
    multiplicand = 4'd3; multiplier = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid busy=%b done=%b product=%h expected 0 0 00", busy, done, product);
    end
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || product !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_nodone done_seen=%b product=%h expected 0 00", saw_done, product);
    end
    do_mult(4'd5, 4'd5, lat, bc, seen);
    checks++;
    if (!seen || lat !== 4 || product !== 8'h19) begin
      failures++;
      $display("FAIL reset_then_5x5 seen=%b lat=%0d product=%h expected 1 4 19", seen, lat, product);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int t;
    multiplicand = 4'd2; multiplier = 4'd3; start = 1'b1;
    tick();
    t = 0;
    while (!done && t < 20) begin
      tick();
      t++;
    end
    checks++;
    if (done !== 1'b1 || t !== 4 || product !== 8'h06) begin
      failures++;
      $display("FAIL b2b_first done=%b cycles=%0d product=%h expected 1 4 06", done, t, product);
    end
    multiplicand = 4'hF; multiplier = 4'hF;
    tick();
    t = 1;
    while (!done && t < 20) begin
      tick();
      t++;
    end
    checks++;
    if (done !== 1'b1 || t !== 5 || product !== 8'h01) begin
      failures++;
      $display("FAIL b2b_second done=%b period=%0d product=%h expected 1 5 01", done, t, product);
    end
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_exhaustive();
    int lat, bc, a, b, e, bad;
    bit seen;
    logic [N-1:0] mc, mp;
    logic [31:0] ev;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        mc = i[N-1:0];
        mp = j[N-1:0];
        a  = $signed(mc);
        b  = $signed(mp);
        e  = a * b;
        ev = e;
        do_mult(mc, mp, lat, bc, seen);
        checks++;
        if (!seen || product !== ev[W-1:0]) begin
          failures++;
          bad++;
          if (bad <= 8)
            $display("FAIL sweep %0d*%0d seen=%b product=%h expected %h", a, b, seen, product, ev[W-1:0]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_corners();
    test_no_restart();
    test_reset_mid();
    test_back_to_back();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
